// File: rtl/char_text_pkg.sv
// Shared state type, character codes and field widths for the character text controller.
// Also holds the single double-dabble step used by the BCD converter.
package char_text_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] CHAR_ZERO  = 8'h30;
    localparam logic [7:0] CHAR_BLANK = 8'h20;

    localparam int NUM_DIGITS = 5;
    localparam int VALUE_W    = 16;
    localparam int DIGIT_W    = 4;
    localparam int BCD_W      = NUM_DIGITS * DIGIT_W;
    localparam int CHAR_W     = 8;

    localparam int ROW_W  = 4;
    localparam int COL_W  = 4;
    localparam int ADDR_W = ROW_W + COL_W;

    // One double-dabble iteration on {bcd, binary}: correct every nibble >= 5, then shift left.
    function automatic logic [BCD_W+VALUE_W-1:0] dabble_step(input logic [BCD_W+VALUE_W-1:0] acc);
        logic [BCD_W+VALUE_W-1:0] a;
        a = acc;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (a[VALUE_W+DIGIT_W*i +: DIGIT_W] >= 4'd5) begin
                a[VALUE_W+DIGIT_W*i +: DIGIT_W] = a[VALUE_W+DIGIT_W*i +: DIGIT_W] + 4'd3;
            end
        end
        return a << 1;
    endfunction

endpackage

// File: rtl/char_text_ctrl_bcd_dabble.sv
// Iterative binary-to-BCD converter: the start edge performs the first shift, so the
// full result and a one-cycle done pulse appear 16 cycles after start.
module bcd_dabble
    import char_text_pkg::*;
(
    input  logic               pclk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [VALUE_W-1:0] value,
    output logic [BCD_W-1:0]   bcd,
    output logic               done
);

    logic [BCD_W+VALUE_W-1:0] acc;
    logic [4:0]               shifts_left;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            shifts_left <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc         <= dabble_step({{BCD_W{1'b0}}, value});
                shifts_left <= 5'(VALUE_W - 1);
            end else if (shifts_left != 5'd0) begin
                acc         <= dabble_step(acc);
                shifts_left <= shifts_left - 5'd1;
                done        <= (shifts_left == 5'd1);
            end
        end
    end

    assign bcd = acc[BCD_W+VALUE_W-1 -: BCD_W];

endmodule

// File: rtl/char_text_ctrl.sv
// Shares the character RAM write port between requesters; each grant is converted to five
// decimal digits and written during vertical blanking. CHAR_TEXT_LZB_EN enables leading-zero blanking.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a request; round-robin grant, latch value/address
// ST_CONV  | binary-to-BCD conversion running in bcd_dabble
// ST_WRITE | one digit per vblank cycle, MSD first, column-only increment
// ST_DONE  | one-cycle ack to the grantee, grant recorded for round-robin
module char_text_ctrl
    import char_text_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                   pclk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_value,
    input  logic [8*NUM_REQ-1:0]   req_addr,
    input  logic                   vblnk_in,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   busy,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [CHAR_W-1:0]      wr_data
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state, state_nxt;
    logic [GW-1:0]       grant, last_grant, arb_idx;
    logic                arb_hit;
    logic [2*NUM_REQ-1:0] req_twice;
    logic [NUM_REQ-1:0]  grant_oh;
    logic [VALUE_W-1:0]  sel_value;
    logic [ADDR_W-1:0]   sel_addr, addr_q;
    logic [2:0]          digit_idx;
    logic                conv_start, conv_done;
    logic [BCD_W-1:0]    bcd;

    function automatic logic [CHAR_W-1:0] digit_code(input logic [BCD_W-1:0] digits,
                                                     input logic [2:0]       idx);
        logic [DIGIT_W-1:0] nib;
        logic               blank;
        nib   = '0;
        blank = 1'b0;
        for (int p = 0; p < NUM_DIGITS; p++) begin
            if (idx == 3'(p)) nib = digits[DIGIT_W*(NUM_DIGITS-1-p) +: DIGIT_W];
        end
`ifdef CHAR_TEXT_LZB_EN
        // Blank while every digit up to and including this one is zero; units digit always shows.
        blank = (idx < 3'(NUM_DIGITS - 1));
        for (int p = 0; p < NUM_DIGITS; p++) begin
            if (3'(p) <= idx && digits[DIGIT_W*(NUM_DIGITS-1-p) +: DIGIT_W] != '0) blank = 1'b0;
        end
`endif
        return blank ? CHAR_BLANK : CHAR_ZERO + CHAR_W'(nib);
    endfunction

    // Doubled request vector turns "first after last_grant, wrapping" into a linear scan.
    assign req_twice = {req, req};

    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int j = 0; j < 2*NUM_REQ; j++) begin
            if (!arb_hit && j > int'(last_grant) && j <= int'(last_grant) + NUM_REQ && req_twice[j]) begin
                arb_hit = 1'b1;
                arb_idx = GW'(j % NUM_REQ);
            end
        end
    end

    always_comb begin
        sel_value = '0;
        sel_addr  = '0;
        grant_oh  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == GW'(i)) begin
                sel_value = req_value[16*i +: 16];
                sel_addr  = req_addr[8*i +: 8];
            end
            grant_oh[i] = (grant == GW'(i));
        end
    end

    always_comb begin
        state_nxt  = state;
        conv_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_hit) begin
                    state_nxt  = ST_CONV;
                    conv_start = 1'b1;
                end
            end
            ST_CONV:  if (conv_done) state_nxt = ST_WRITE;
            ST_WRITE: if (vblnk_in && digit_idx == 3'(NUM_DIGITS - 1)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign wr_en = (state == ST_WRITE) && vblnk_in;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            ack        <= '0;
            grant      <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            addr_q     <= '0;
            digit_idx  <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
            ack   <= (state_nxt == ST_DONE) ? grant_oh : '0;
            if (state == ST_IDLE && arb_hit) begin
                grant  <= arb_idx;
                addr_q <= sel_addr;
            end
            if (state == ST_DONE) last_grant <= grant;
            if (state == ST_CONV && conv_done) begin
                digit_idx <= '0;
                wr_addr   <= addr_q;
                wr_data   <= digit_code(bcd, 3'd0);
            end else if (wr_en) begin
                // Column wraps within the row; the row field is never carried into.
                digit_idx <= digit_idx + 3'd1;
                wr_addr   <= {wr_addr[ADDR_W-1:COL_W], wr_addr[COL_W-1:0] + 4'd1};
                wr_data   <= digit_code(bcd, digit_idx + 3'd1);
            end
        end
    end

    bcd_dabble u_dabble (
        .pclk  (pclk),
        .rst_n (rst_n),
        .start (conv_start),
        .value (sel_value),
        .bcd   (bcd),
        .done  (conv_done)
    );

endmodule

// File: tb/tb_char_text_ctrl.sv
// Self-checking bench for char_text_ctrl: directed vector table, randomized transactions
// against a decimal-arithmetic reference model, and round-robin / reset sequences.
module tb_char_text_ctrl;

    localparam int NR = 2;
`ifdef CHAR_TEXT_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic              pclk;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [16*NR-1:0]  req_value;
    logic [8*NR-1:0]   req_addr;
    logic              vblnk_in;
    logic [NR-1:0]     ack;
    logic              busy;
    logic              wr_en;
    logic [7:0]        wr_addr;
    logic [7:0]        wr_data;

    char_text_ctrl #(.NUM_REQ(NR)) dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .req       (req),
        .req_value (req_value),
        .req_addr  (req_addr),
        .vblnk_in  (vblnk_in),
        .ack       (ack),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        int              ri;
        logic [15:0]     value;
        logic [7:0]      addr;
        int              gs;
        int              gl;
        logic [4:0][7:0] ea;
        logic [4:0][7:0] ed;
        int              eack;
    } vec_t;

    vec_t            tbl[5];
    int              n_cmp = 0;
    int              n_err = 0;
    logic [7:0]      obs_a[$];
    logic [7:0]      obs_d[$];
    logic [NR-1:0]   order[$];
    int              obs_ack_cyc, obs_ack_cnt, obs_gap_bad;
    logic [NR-1:0]   obs_ack_val;
    logic            obs_busy1, obs_busy_end;
    logic [7:0]      zch;
    logic [4:0][7:0] ea, ed;
    logic [NR-1:0]   lower, raise;
    int              r_ri, r_gs, r_gl;
    logic [15:0]     r_v;
    logic [7:0]      r_a;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] model_char(input int v, input int p);
        int pw;
        pw = 1;
        for (int i = 0; i < 4 - p; i++) pw = pw * 10;
        if (LZB && p < 4 && v < pw) return 8'h20;
        return 8'(48 + (v / pw) % 10);
    endfunction

    function automatic logic [7:0] model_addr(input logic [7:0] a, input int p);
        return {a[7:4], 4'((int'(a[3:0]) + p) % 16)};
    endfunction

    function automatic int model_ack(input int gs, input int gl);
        int n;
        n = 0;
        for (int c = 17; c < 400; c++) begin
            if (!(c >= gs && c < gs + gl)) n++;
            if (n == 5) return c + 1;
        end
        return -2;
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic run_txn(input int ri, input logic [15:0] v, input logic [7:0] a,
                           input int gs, input int gl);
        bit drop;
        drop = 1'b0;
        tick();
        req_value[16*ri +: 16] = v;
        req_addr[8*ri +: 8]    = a;
        req[ri]                = 1'b1;
        vblnk_in               = 1'b1;
        obs_a.delete();
        obs_d.delete();
        obs_ack_cyc = -1;
        obs_ack_cnt = 0;
        obs_gap_bad = 0;
        obs_ack_val = '0;
        obs_busy1   = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            tick();
            if (drop) begin
                req[ri] = 1'b0;
                drop    = 1'b0;
            end
            vblnk_in = !(k >= gs && k < gs + gl);
            @(negedge pclk);
            if (k == 1) obs_busy1 = busy;
            if (!vblnk_in && wr_en) obs_gap_bad++;
            if (wr_en) begin
                obs_a.push_back(wr_addr);
                obs_d.push_back(wr_data);
            end else if (!vblnk_in && k >= 17 && obs_a.size() < 5) begin
                if (wr_addr != model_addr(a, obs_a.size())) obs_gap_bad++;
            end
            if (ack != '0) begin
                if (obs_ack_cnt == 0) begin
                    obs_ack_cyc = k;
                    obs_ack_val = ack;
                end
                obs_ack_cnt++;
                drop = 1'b1;
            end
            if (obs_ack_cyc >= 0 && k == obs_ack_cyc + 1) begin
                obs_busy_end = busy;
                break;
            end
        end
        req[ri]  = 1'b0;
        vblnk_in = 1'b1;
    endtask

    task automatic compare_txn(input string tag, input int ri, input logic [4:0][7:0] xa,
                               input logic [4:0][7:0] xd, input int eack);
        logic [NR-1:0] ev;
        ev     = '0;
        ev[ri] = 1'b1;
        check({tag, ".nwr"}, obs_a.size(), 5);
        for (int p = 0; p < 5; p++) begin
            if (p < obs_a.size()) begin
                check($sformatf("%s.addr%0d", tag, p), obs_a[p], xa[p]);
                check($sformatf("%s.data%0d", tag, p), obs_d[p], xd[p]);
            end
        end
        check({tag, ".ack_cyc"}, obs_ack_cyc, eack);
        check({tag, ".ack_val"}, obs_ack_val, ev);
        check({tag, ".ack_cnt"}, obs_ack_cnt, 1);
        check({tag, ".gap"}, obs_gap_bad, 0);
        check({tag, ".busy1"}, obs_busy1, 1);
        check({tag, ".busy_end"}, obs_busy_end, 0);
    endtask

    task automatic serve_one(input int bound);
        obs_a.delete();
        obs_d.delete();
        obs_ack_cyc = -1;
        obs_ack_val = '0;
        for (int k = 1; k <= bound; k++) begin
            tick();
            if (obs_ack_cyc >= 0) begin
                req = req & ~obs_ack_val;
                break;
            end
            @(negedge pclk);
            if (wr_en) begin
                obs_a.push_back(wr_addr);
                obs_d.push_back(wr_data);
            end
            if (ack != '0 && obs_ack_cyc < 0) begin
                obs_ack_cyc = k;
                obs_ack_val = ack;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        zch = LZB ? 8'h20 : 8'h30;
        tbl[0].ri = 0; tbl[0].value = 16'd1234;  tbl[0].addr = 8'h12; tbl[0].gs = 0;  tbl[0].gl = 0;
        tbl[0].ea = {8'h16, 8'h15, 8'h14, 8'h13, 8'h12};
        tbl[0].ed = {8'h34, 8'h33, 8'h32, 8'h31, zch};                 tbl[0].eack = 22;
        tbl[1].ri = 1; tbl[1].value = 16'd65535; tbl[1].addr = 8'h40; tbl[1].gs = 0;  tbl[1].gl = 0;
        tbl[1].ea = {8'h44, 8'h43, 8'h42, 8'h41, 8'h40};
        tbl[1].ed = {8'h35, 8'h33, 8'h35, 8'h35, 8'h36};               tbl[1].eack = 22;
        tbl[2].ri = 0; tbl[2].value = 16'd0;     tbl[2].addr = 8'hA0; tbl[2].gs = 0;  tbl[2].gl = 0;
        tbl[2].ea = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tbl[2].ed = {8'h30, zch, zch, zch, zch};                       tbl[2].eack = 22;
        tbl[3].ri = 1; tbl[3].value = 16'd7;     tbl[3].addr = 8'h2D; tbl[3].gs = 0;  tbl[3].gl = 0;
        tbl[3].ea = {8'h21, 8'h20, 8'h2F, 8'h2E, 8'h2D};
        tbl[3].ed = {8'h37, zch, zch, zch, zch};                       tbl[3].eack = 22;
        tbl[4].ri = 0; tbl[4].value = 16'd40961; tbl[4].addr = 8'h55; tbl[4].gs = 19; tbl[4].gl = 10;
        tbl[4].ea = {8'h59, 8'h58, 8'h57, 8'h56, 8'h55};
        tbl[4].ed = {8'h31, 8'h36, 8'h39, 8'h30, 8'h34};               tbl[4].eack = 32;

        rst_n = 1'b0; req = '0; req_value = '0; req_addr = '0; vblnk_in = 1'b1;
        #2;
        check("reset.busy", busy, 0);
        check("reset.ack", ack, 0);
        check("reset.wr_en", wr_en, 0);
        check("reset.wr_addr", wr_addr, 0);
        check("reset.wr_data", wr_data, 0);
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            run_txn(tbl[t].ri, tbl[t].value, tbl[t].addr, tbl[t].gs, tbl[t].gl);
            compare_txn($sformatf("vec%0d", t), tbl[t].ri, tbl[t].ea, tbl[t].ed, tbl[t].eack);
        end

        for (int n = 0; n < 16; n++) begin
            r_ri = int'($urandom_range(0, 1));
            r_v  = 16'($urandom_range(0, 65535));
            r_a  = 8'($urandom_range(0, 255));
            r_gs = int'($urandom_range(15, 21));
            r_gl = int'($urandom_range(0, 6));
            for (int p = 0; p < 5; p++) begin
                ea[p] = model_addr(r_a, p);
                ed[p] = model_char(int'(r_v), p);
            end
            run_txn(r_ri, r_v, r_a, r_gs, r_gl);
            compare_txn($sformatf("rnd%0d", n), r_ri, ea, ed, model_ack(r_gs, r_gl));
        end

        // Round-robin: both requesters held, each re-raised one cycle after its ack.
        tick(); rst_n = 1'b0; #1; @(negedge pclk); rst_n = 1'b1;
        tick();
        req_value = {16'd50000, 16'd123};
        req_addr  = {8'h7E, 8'h30};
        req = 2'b11; vblnk_in = 1'b1;
        lower = '0; raise = '0;
        obs_a.delete(); obs_d.delete(); order.delete();
        for (int k = 1; k <= 200 && order.size() < 4; k++) begin
            tick();
            req   = (req | raise) & ~lower;
            raise = lower;
            lower = '0;
            @(negedge pclk);
            if (wr_en) begin
                obs_a.push_back(wr_addr);
                obs_d.push_back(wr_data);
            end
            if (ack != '0) begin
                order.push_back(ack);
                lower = ack;
            end
        end
        req = '0;
        for (int i = 0; i < 4; i++)
            check($sformatf("rr.order%0d", i), (i < order.size()) ? order[i] : 2'b00,
                  (i % 2 == 0) ? 2'b01 : 2'b10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("rr.data%0d", i), (i < obs_d.size()) ? obs_d[i] : 8'h00,
                  (i < 5) ? model_char(123, i) : model_char(50000, i - 5));
            check($sformatf("rr.addr%0d", i), (i < obs_a.size()) ? obs_a[i] : 8'h00,
                  (i < 5) ? model_addr(8'h30, i) : model_addr(8'h7E, i - 5));
        end
        repeat (3) tick();

        // Reset during conversion: nothing acked, then req1 served since req0 is low.
        tick();
        req_value[15:0] = 16'd999; req_addr[7:0] = 8'h10; req = 2'b01;
        repeat (7) tick();
        @(negedge pclk);
        check("rst.busy_before", busy, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst.busy", busy, 0);
        check("rst.wr_en", wr_en, 0);
        check("rst.ack", ack, 0);
        req = 2'b10; req_value[31:16] = 16'd321; req_addr[15:8] = 8'h60;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        serve_one(60);
        req = '0;
        check("rst.ack_val", obs_ack_val, 2'b10);
        check("rst.ack_cyc", obs_ack_cyc, 22);
        check("rst.nwr", obs_a.size(), 5);
        for (int p = 0; p < 5; p++) begin
            if (p < obs_a.size()) begin
                check($sformatf("rst.addr%0d", p), obs_a[p], model_addr(8'h60, p));
                check($sformatf("rst.data%0d", p), obs_d[p], model_char(321, p));
            end
        end
        repeat (3) tick();

        // After reset with both requesting, req0 wins.
        rst_n = 1'b0;
        req = 2'b11;
        @(negedge pclk);
        rst_n = 1'b1;
        serve_one(60);
        req = '0;
        check("rst2.ack_val", obs_ack_val, 2'b01);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
